// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, stalls on MemReady, and drives every datapath strobe and select.
module multicycle_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  state_t state;
  ctrl_t  c;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else begin
      case (state)
        S_FETCH:   state <= MemReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= S_MEMADDR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDIEX;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADDR: state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state <= MemReady ? S_MEMWB : S_MEMRD;
        S_MEMWB:   state <= S_FETCH;
        S_MEMWR:   state <= MemReady ? S_FETCH : S_MEMWR;
        S_EXEC:    state <= S_RWB;
        S_RWB:     state <= S_FETCH;
        S_BRANCH:  state <= S_FETCH;
        S_JUMP:    state <= S_FETCH;
        S_ADDIEX:  state <= S_ADDIWB;
        S_ADDIWB:  state <= S_FETCH;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Reset forces every output low so an aborted instruction issues no write strobe.
  always_comb begin
    c = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = 2'b01;
          c.ir_write  = MemReady;
          c.pc_write  = MemReady;
        end
        S_DECODE: begin
          c.alu_src_b = 2'b11;
          case (Op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: c.illegal_op = 1'b0;
            default:                                   c.illegal_op = 1'b1;
          endcase
        end
        S_MEMADDR: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          c.mem_read = 1'b1;
          c.iord     = 1'b1;
        end
        S_MEMWB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          c.mem_write = 1'b1;
          c.iord      = 1'b1;
        end
        S_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_op    = 2'b10;
        end
        S_RWB: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          c.alu_src_a     = 1'b1;
          c.alu_op        = 2'b01;
          c.pc_write_cond = 1'b1;
          c.pc_source     = 2'b01;
        end
        S_JUMP: begin
          c.pc_write  = 1'b1;
          c.pc_source = 2'b10;
        end
        S_ADDIEX: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'b10;
        end
        S_ADDIWB: c.reg_write = 1'b1;
        default: c = '0;
      endcase
    end
  end

  assign PCWrite     = c.pc_write;
  assign PCWriteCond = c.pc_write_cond;
  assign IorD        = c.iord;
  assign MemRead     = c.mem_read;
  assign MemWrite    = c.mem_write;
  assign MemtoReg    = c.mem_to_reg;
  assign IRWrite     = c.ir_write;
  assign ALUSrcA     = c.alu_src_a;
  assign RegWrite    = c.reg_write;
  assign RegDst      = c.reg_dst;
  assign PCSource    = c.pc_source;
  assign ALUSrcB     = c.alu_src_b;
  assign ALUOp       = c.alu_op;
  assign IllegalOp   = c.illegal_op;
  assign State       = reset ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_multicycle_main_control;

  logic       clk, reset, MemReady;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  PCSource,ALUSrcB,ALUOp,IllegalOp,State}
  typedef struct {
    logic [20:0] v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  function automatic logic [20:0] pack(bit pcw, bit pcwc, bit iord, bit mrd, bit mwr, bit m2r,
                                       bit irw, bit srca, bit rw, bit rd, logic [1:0] pcs,
                                       logic [1:0] srcb, logic [1:0] aop, bit ill, int st);
    logic [3:0] s;
    s = st[3:0];
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, pcs, srcb, aop, ill, s};
  endfunction

  // Hand-written output table for each state the directed sequences visit.
  function automatic logic [20:0] expect_for(bit rst, int st, bit mr, logic [5:0] op);
    bit ill;
    ill = !(op == R || op == LW || op == SW || op == BEQ || op == J || op == ADDI);
    if (rst) return '0;
    case (st)
      0:  return pack(mr,0,0,1,0,0,mr,0,0,0,2'b00,2'b01,2'b00,0,0);
      1:  return pack(0,0,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,ill,1);
      2:  return pack(0,0,0,0,0,0,0,1,0,0,2'b00,2'b10,2'b00,0,2);
      3:  return pack(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,3);
      4:  return pack(0,0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0,4);
      5:  return pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,5);
      6:  return pack(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b10,0,6);
      7:  return pack(0,0,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,0,7);
      8:  return pack(0,1,0,0,0,0,0,1,0,0,2'b01,2'b00,2'b01,0,8);
      9:  return pack(1,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0,9);
      10: return pack(0,0,0,0,0,0,0,1,0,0,2'b00,2'b10,2'b00,0,10);
      11: return pack(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,11);
      default: return '0;
    endcase
  endfunction

  task automatic step(bit rst, bit mr, logic [5:0] op, int st);
    exp_t e;
    reset    = rst;
    MemReady = mr;
    Op       = op;
    e.v      = expect_for(rst, st, mr, op);
    e.cyc    = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      logic [20:0] got;
      e   = q.pop_front();
      got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
             RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, IllegalOp, State};
      tests++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL cycle%0d outputs: got %06h (State=%0d) expected %06h (State=%0d)",
                 e.cyc, got, got[3:0], e.v, e.v[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; MemReady = 1'b1; Op = R;
    @(posedge clk); #1;
    // Reset held: all outputs zero.
    step(1, 1, R, 0); step(1, 1, R, 0); step(1, 1, R, 0);
    // R-type, zero wait.
    step(0, 1, R, 0); step(0, 1, R, 1); step(0, 1, R, 6); step(0, 1, R, 7);
    // lw with 2 Fetch waits and 3 MemRd waits.
    step(0, 0, LW, 0); step(0, 0, LW, 0); step(0, 1, LW, 0); step(0, 1, LW, 1);
    step(0, 1, LW, 2); step(0, 0, LW, 3); step(0, 0, LW, 3); step(0, 0, LW, 3);
    step(0, 1, LW, 3); step(0, 1, LW, 4);
    // sw, with MemReady low in states that must ignore it.
    step(0, 1, SW, 0); step(0, 0, SW, 1); step(0, 0, SW, 2); step(0, 1, SW, 5);
    // beq.
    step(0, 1, BEQ, 0); step(0, 1, BEQ, 1); step(0, 1, BEQ, 8);
    // j.
    step(0, 1, J, 0); step(0, 1, J, 1); step(0, 1, J, 9);
    // addi.
    step(0, 1, ADDI, 0); step(0, 0, ADDI, 1); step(0, 1, ADDI, 10); step(0, 0, ADDI, 11);
    // Illegal opcode: two cycles, back to Fetch.
    step(0, 1, BAD, 0); step(0, 1, BAD, 1);
    // sw stalled in MemWr for one cycle.
    step(0, 1, SW, 0); step(0, 1, SW, 1); step(0, 1, SW, 2); step(0, 0, SW, 5);
    step(0, 1, SW, 5);
    // lw aborted by reset while waiting in MemRd.
    step(0, 1, LW, 0); step(0, 1, LW, 1); step(0, 1, LW, 2); step(0, 0, LW, 3);
    step(1, 0, LW, 0); step(1, 1, LW, 0);
    step(0, 0, LW, 0); step(0, 1, LW, 0); step(0, 1, LW, 1);
    @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control unit for the multi-cycle MIPS datapath. It is the producer of the 2-bit `ALUOp` code that the ALU control decoder consumes: 00 = add, 01 = subtract, 10 = decode from Funct. It also drives every other datapath strobe and mux select from a Moore state machine. The state machine sequences each instruction through fetch, decode, execute, memory and write-back steps, and stalls on a memory-ready handshake.

## Interface
- No parameters; opcodes and state codes are fixed constants inside the block.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  6  opcode field `IR[31:26]`; stable from Decode until the next Fetch.
- `MemReady`  in  1  memory completion; sampled in Fetch, MemRd and MemWr.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath strobes and selects.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcB`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = use Funct.
- `IllegalOp`  out  1  one-cycle flag for an unrecognised opcode.
- `State`  out  4  current state code, for debug.

## Operation
- Recognised opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- Any output not listed for a state is 0.
- States and their outputs:
  - Fetch(0): MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=MemReady; this is the only Mealy term. Stays in Fetch while MemReady=0, goes to Decode when MemReady=1.
  - Decode(1): ALUSrcB=11, ALUOp=00 (branch-target precompute). Next state by Op:
    - lw or sw → MemAddr
    - R-type → Exec
    - beq → Branch
    - j → Jump
    - addi → AddiExec
    - other → Fetch, with IllegalOp=1 in this cycle only
  - MemAddr(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MemRd for lw, MemWr for sw.
  - MemRd(3): MemRead=1, IorD=1. Waits for MemReady, then goes to MemWB.
  - MemWB(4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to Fetch.
  - MemWr(5): MemWrite=1, IorD=1. Waits for MemReady, then goes to Fetch.
  - Exec(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
  - RWB(7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to Fetch.
  - Branch(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to Fetch.
  - Jump(9): PCWrite=1, PCSource=10. Goes to Fetch.
  - AddiExec(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to AddiWB.
  - AddiWB(11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to Fetch.
- Unused codes 12–15 go to Fetch on the next edge, with all outputs 0.
- `MemRead` and `MemWrite` are never high together.
- `MemRead`/`MemWrite` are held high for the whole wait in Fetch/MemRd/MemWr.
- `Op` is only sampled in Decode and MemAddr.

## Timing
- Reset:
  - While `reset`=1, every output is 0, including `ALUOp`=00, `PCSource`=00 and `State`=0.
  - The state register loads Fetch at each rising edge where `reset`=1.
  - The first Fetch outputs appear in the cycle after the edge where `reset` is sampled 0.
- Reset mid-instruction: the instruction is aborted with no write strobe in any cycle with `reset`=1. Fetch is the state in the first cycle after reset release.
- Outputs are decoded combinationally from the state register. The one exception is the Fetch `IRWrite`/`PCWrite` term, which is combinational from `MemReady`.
- Cycles per instruction with zero wait (MemReady=1 whenever sampled):
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle `MemReady` is low in Fetch, MemRd or MemWr adds one cycle.
- `MemReady` asserted in any other state is ignored.

## Test plan
- Reset: hold `reset` for 3 cycles with MemReady=1 → all outputs 0. Release → next cycle State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type, Op=000000, MemReady=1:
  - State sequence 0,1,6,7,0.
  - ALUOp is 00 in cycles 1–2 and 10 in cycle 3.
  - RegWrite=1 and RegDst=1 only in cycle 4.
- lw with waits, Op=100011, MemReady=0 for the first 2 Fetch cycles and the first 3 MemRd cycles:
  - Sequence 0,0,0,1,2,3,3,3,3,4,0.
  - IRWrite is high only in the third Fetch cycle.
  - MemtoReg=1 in state 4.
- sw then beq:
  - sw gives sequence 0,1,2,5,0 with MemWrite=1 only in state 5 and IorD=1.
  - beq gives sequence 0,1,8,0 with ALUOp=01, PCWriteCond=1 and PCSource=01 in state 8.
- j and addi:
  - j gives 0,1,9,0 with PCWrite=1 and PCSource=10 in state 9.
  - addi gives 0,1,10,11,0 with ALUSrcB=10 in state 10 and RegWrite=1, RegDst=0 in state 11.
- Illegal opcode and mid-instruction reset:
  - Op=111111 gives 0,1,0 with IllegalOp=1 only in state 1.
  - Asserting `reset` while in MemRd gives all outputs 0 during reset, then State=0 after release.
